// File: rtl/bus_arb_if.sv
// Signal bundle between the two bus masters, the arbiter and the shared system bus.
// slave = arbiter view; master = view of the masters and bus devices around it.
interface bus_arb_if;
  logic        m0_stb;
  logic        m0_we;
  logic [21:0] m0_addr;
  logic [31:0] m0_dout;
  logic [31:0] m0_din;
  logic        m0_ack;
  logic        m0_err;

  logic        m1_stb;
  logic        m1_we;
  logic [21:0] m1_addr;
  logic [31:0] m1_dout;
  logic [31:0] m1_din;
  logic        m1_ack;
  logic        m1_err;

  logic        bus_stb;
  logic        bus_we;
  logic [21:0] bus_addr;
  logic [31:0] bus_dout;
  logic [31:0] bus_din;
  logic        bus_ack;

  modport slave (
    input  m0_stb, m0_we, m0_addr, m0_dout,
    output m0_din, m0_ack, m0_err,
    input  m1_stb, m1_we, m1_addr, m1_dout,
    output m1_din, m1_ack, m1_err,
    output bus_stb, bus_we, bus_addr, bus_dout,
    input  bus_din, bus_ack
  );

  modport master (
    output m0_stb, m0_we, m0_addr, m0_dout,
    input  m0_din, m0_ack, m0_err,
    output m1_stb, m1_we, m1_addr, m1_dout,
    input  m1_din, m1_ack, m1_err,
    input  bus_stb, bus_we, bus_addr, bus_dout,
    output bus_din, bus_ack
  );
endinterface

// File: rtl/bus_arb.sv
// Two-master round-robin bus arbiter with a per-transaction timeout that returns an error ack.
// Grant costs one cycle; data and ack pass through combinationally; owner holds the bus until ack/drop/timeout.
module bus_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  bus_arb_if.slave   bif,
  output logic [1:0] o_grant,
  output logic [7:0] o_err_cnt
);
  // Encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_t;

  localparam logic [15:0] LP_LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_last;
  logic [15:0] r_wait;
  logic [7:0]  r_err_cnt;

  logic w_own;
  logic w_own_stb;
  logic w_timeout;
  logic w_exit;

  assign w_own     = (r_state != ST_IDLE);
  assign w_own_stb = (r_state == ST_OWN1) ? bif.m1_stb : bif.m0_stb;
  // A real ack in the final wait cycle beats the timeout.
  assign w_timeout = w_own && w_own_stb && !bif.bus_ack && (r_wait == LP_LAST_WAIT);
  assign w_exit    = w_own && (bif.bus_ack || !w_own_stb || w_timeout);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bif.m0_stb && bif.m1_stb) begin
          w_next = r_last ? ST_OWN0 : ST_OWN1;
        end else if (bif.m0_stb) begin
          w_next = ST_OWN0;
        end else if (bif.m1_stb) begin
          w_next = ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (w_exit) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last    <= 1'b1;
      r_wait    <= '0;
      r_err_cnt <= '0;
    end else begin
      r_wait <= w_own ? r_wait + 16'd1 : 16'd0;
      if (w_exit) begin
        r_last <= (r_state == ST_OWN1);
      end
      if (w_timeout && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    bif.bus_stb  = 1'b0;
    bif.bus_we   = 1'b0;
    bif.bus_addr = '0;
    bif.bus_dout = '0;
    bif.m0_din   = '0;
    bif.m0_ack   = 1'b0;
    bif.m0_err   = 1'b0;
    bif.m1_din   = '0;
    bif.m1_ack   = 1'b0;
    bif.m1_err   = 1'b0;
    case (r_state)
      ST_OWN0: begin
        bif.bus_stb  = bif.m0_stb & ~w_timeout;
        bif.bus_we   = bif.m0_we;
        bif.bus_addr = bif.m0_addr;
        bif.bus_dout = bif.m0_dout;
        bif.m0_din   = w_timeout ? 32'h0 : bif.bus_din;
        bif.m0_ack   = bif.bus_ack | w_timeout;
        bif.m0_err   = w_timeout;
      end
      ST_OWN1: begin
        bif.bus_stb  = bif.m1_stb & ~w_timeout;
        bif.bus_we   = bif.m1_we;
        bif.bus_addr = bif.m1_addr;
        bif.bus_dout = bif.m1_dout;
        bif.m1_din   = w_timeout ? 32'h0 : bif.bus_din;
        bif.m1_ack   = bif.bus_ack | w_timeout;
        bif.m1_err   = w_timeout;
      end
      default: ;
    endcase
  end

  assign o_grant   = r_state;
  assign o_err_cnt = r_err_cnt;
endmodule

// File: doc/bus_arb.md
# bus_arb

Two-master bus arbiter and bus-timeout guard sitting between the masters (CPU and a second master such as a DMA or debug port) and the shared system bus (stb/we/addr/data/ack) that feeds the address decoder, PROM, SDRAM and IO devices. It grants the bus to one master per transaction using round-robin priority. It forwards data and ack between the granted master and the bus. It terminates any transaction the addressed device never acknowledges with an error ack, so an unmapped address cannot hang a master.

## Interface
- timeout_cycles, 1023: bus cycles a granted transaction may wait for bus_ack before forced termination; legal range 2..65535.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active low.
- m0_stb / m1_stb  in  1  master request; held high with we/addr/dout stable until that master's ack.
- m0_we / m1_we  in  1  write enable.
- m0_addr / m1_addr  in  22  word address [23:2].
- m0_dout / m1_dout  in  32  write data from master.
- m0_din / m1_din  out  32  read data to master.
- m0_ack / m1_ack  out  1  transaction complete, one-cycle pulse.
- m0_err / m1_err  out  1  asserted with ack when the transaction timed out.
- bus_stb  out  1  strobe to address decoder.
- bus_we  out  1  write enable to bus.
- bus_addr  out  22  word address [23:2] to bus.
- bus_dout  out  32  write data to bus.
- bus_din  in  32  read data from bus.
- bus_ack  in  1  ack from the bus ack mux.
- grant  out  2  one-hot current owner: bit0 = m0, bit1 = m1, 00 = idle.
- err_cnt  out  8  saturating count of timeouts.

## Operation
- Registered state: IDLE, OWN0, OWN1.
- Also registered: last (last served master, 1 bit), wait counter (16 bits), err_cnt.
- IDLE:
  - m0_stb only -> OWN0.
  - m1_stb only -> OWN1.
  - Both -> the master not equal to last.
  - Neither -> stay in IDLE.
- OWNx datapath:
  - bus_stb = mx_stb; bus_we/addr/dout muxed from mx.
  - mx_din = bus_din and mx_ack = bus_ack, combinationally.
  - The non-owner sees ack = 0, err = 0, din = 0.
- OWNx exits to IDLE on any of:
  - bus_ack = 1. Set last = x.
  - Owner drops mx_stb (protocol violation). Exit with no ack to the master; last = x.
  - Timeout: counter == timeout_cycles-1 and bus_ack = 0.
    - In that same cycle: mx_ack = 1, mx_err = 1, mx_din = 0, bus_stb forced 0.
    - err_cnt increments, saturating at 255. last = x.
- Wait counter clears on entry to OWNx and increments every OWNx cycle.
- If bus_ack and timeout coincide, bus_ack wins: normal ack, err = 0, err_cnt unchanged.
- In IDLE: bus_stb = 0 and bus_we/addr/dout = 0.
- grant mirrors the state.
- Reset values (async, rst_n low): state IDLE, last = 1 (so m0 wins the first contention), counter 0, err_cnt 0.
  - All outputs 0: bus_stb, bus_we, bus_addr, bus_dout, m*_ack, m*_err, m*_din, grant.
- Reset asserted mid-transaction: bus_stb drops immediately and no ack is issued.

## Timing
- Request sampled in IDLE at cycle N -> bus_stb high at N+1; the arbiter adds one cycle of latency.
- bus_ack at cycle M -> mx_ack at cycle M, zero added latency. State is IDLE at M+1.
- Earliest next grant is at M+2. A master that re-asserts stb at M+1 is sampled at M+1.
- Timeout: with bus_stb first high at N+1, the err ack occurs at cycle N+timeout_cycles unless bus_ack arrives earlier.
- Round-robin under continuous contention alternates grants; no master waits more than one foreign transaction.
- A late bus_ack after a timeout, arriving while in IDLE, is ignored.

## Test plan
- Single m0 read:
  - Stimulus: m0_stb at cycle 1, addr 0x000100; device acks 3 cycles after bus_stb, bus_din 0xDEADBEEF.
  - Required: grant 01 from cycle 2; m0_din 0xDEADBEEF with m0_ack at cycle 5; m0_err 0; m1_ack never set.
- Simultaneous contention after reset:
  - Stimulus: m0 and m1 both request continuously; device acks each transaction after 1 cycle.
  - Required: grant order m0, m1, m0, m1; each ack goes only to the owner; bus_addr follows the owner.
- Timeout:
  - Stimulus: timeout_cycles = 8; m1 requests an unmapped address; bus_ack held 0.
  - Required: m1_ack = m1_err = 1 exactly 8 cycles after the request cycle; bus_stb = 0 that cycle; err_cnt = 1; IDLE next cycle.
- Ack/timeout coincidence and late ack:
  - Ack coincident with the timeout cycle -> err = 0 and err_cnt unchanged.
  - bus_ack pulse while IDLE -> no master ack.
- err_cnt saturation:
  - Stimulus: 260 consecutive timeouts with timeout_cycles = 2.
  - Required: err_cnt = 255 and holds.
- Reset mid-transaction:
  - Stimulus: rst_n low while in OWN0 waiting for ack.
  - Required: bus_stb, grant and acks 0 asynchronously; after release, m0 and m1 requesting together -> m0 granted first.
